// File: rtl/neighbor_scan.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | neighbor_scan: walks the point RAM for one query point, feeds the distance |
// | comparator and streams matching indices over valid/ready.                 |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module neighbor_scan #(
   parameter int IDX_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [IDX_W-1:0] query_idx,
   input  logic [IDX_W:0]   n_points,
   input  logic [15:0]      r2_in,
   output logic             busy,
   output logic             done,
   output logic             mem_rd_en,
   output logic [IDX_W-1:0] mem_addr,
   input  logic [23:0]      mem_rdata,
   output logic [7:0]       x1,
   output logic [7:0]       y1,
   output logic [7:0]       z1,
   output logic [7:0]       x2,
   output logic [7:0]       y2,
   output logic [7:0]       z2,
   output logic [15:0]      r2,
   input  logic             is_neighbor,
   output logic             nb_valid,
   input  logic             nb_ready,
   output logic [IDX_W-1:0] nb_idx,
   output logic [IDX_W:0]   nb_count
);

   localparam logic [2:0] c_IDLE  = 3'd0;
   localparam logic [2:0] c_Q_RD  = 3'd1;
   localparam logic [2:0] c_Q_CAP = 3'd2;
   localparam logic [2:0] c_C_RD  = 3'd3;
   localparam logic [2:0] c_C_CAP = 3'd4;
   localparam logic [2:0] c_C_EV  = 3'd5;
   localparam logic [2:0] c_EMIT  = 3'd6;
   localparam logic [2:0] c_DONE  = 3'd7;

   localparam logic [IDX_W:0] c_ONE  = {{IDX_W{1'b0}}, 1'b1};
   localparam logic [IDX_W:0] c_ZERO = '0;

   logic [2:0]       r_state;
   logic [IDX_W-1:0] r_query;
   logic [IDX_W:0]   r_n;
   logic [IDX_W-1:0] r_j;
   logic [IDX_W-1:0] r_nb_idx;
   logic [IDX_W:0]   r_count;
   logic [15:0]      r_r2;
   logic [7:0]       r_x1, r_y1, r_z1, r_x2, r_y2, r_z2;

   logic w_last;
   logic w_hit;

   // Completion is decided on j itself so a full 2^IDX_W scan never wraps j.
   assign w_last = ({1'b0, r_j} == (r_n - c_ONE));
   assign w_hit  = is_neighbor && (r_j != r_query);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state  <= c_IDLE;
         r_query  <= '0;
         r_n      <= '0;
         r_j      <= '0;
         r_nb_idx <= '0;
         r_count  <= '0;
         r_r2     <= '0;
         r_x1     <= '0;
         r_y1     <= '0;
         r_z1     <= '0;
         r_x2     <= '0;
         r_y2     <= '0;
         r_z2     <= '0;
      end else begin
         case (r_state)
            c_IDLE: begin
               if (start) begin
                  r_query <= query_idx;
                  r_n     <= n_points;
                  r_r2    <= r2_in;
                  r_count <= '0;
                  r_j     <= '0;
                  r_state <= (n_points == c_ZERO) ? c_DONE : c_Q_RD;
               end
            end
            c_Q_RD: r_state <= c_Q_CAP;
            c_Q_CAP: begin
               r_x1    <= mem_rdata[23:16];
               r_y1    <= mem_rdata[15:8];
               r_z1    <= mem_rdata[7:0];
               r_state <= c_C_RD;
            end
            c_C_RD: r_state <= c_C_CAP;
            c_C_CAP: begin
               r_x2    <= mem_rdata[23:16];
               r_y2    <= mem_rdata[15:8];
               r_z2    <= mem_rdata[7:0];
               r_state <= c_C_EV;
            end
            c_C_EV: begin
               if (w_hit) begin
                  r_nb_idx <= r_j;
                  r_state  <= c_EMIT;
               end else if (w_last) begin
                  r_state <= c_DONE;
               end else begin
                  r_j     <= r_j + 1'b1;
                  r_state <= c_C_RD;
               end
            end
            c_EMIT: begin
               if (nb_ready) begin
                  r_count <= r_count + c_ONE;
                  if (w_last) begin
                     r_state <= c_DONE;
                  end else begin
                     r_j     <= r_j + 1'b1;
                     r_state <= c_C_RD;
                  end
               end
            end
            c_DONE:  r_state <= c_IDLE;
            default: r_state <= c_IDLE;
         endcase
      end
   end

   assign busy      = (r_state != c_IDLE);
   assign done      = (r_state == c_DONE);
   assign nb_valid  = (r_state == c_EMIT);
   assign mem_rd_en = (r_state == c_Q_RD) || (r_state == c_C_RD);
   assign mem_addr  = (r_state == c_Q_RD) ? r_query :
                      (r_state == c_C_RD) ? r_j : '0;
   assign nb_idx    = r_nb_idx;
   assign nb_count  = r_count;
   assign r2        = r_r2;
   assign x1        = r_x1;
   assign y1        = r_y1;
   assign z1        = r_z1;
   assign x2        = r_x2;
   assign y2        = r_y2;
   assign z2        = r_z2;

endmodule
`default_nettype wire

// File: tb/tb_neighbor_scan.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_neighbor_scan: directed and random scans against a list-based model.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_neighbor_scan;

   localparam int IDX_W = 4;
   localparam int NP    = 16;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             start;
   logic [IDX_W-1:0] query_idx;
   logic [IDX_W:0]   n_points;
   logic [15:0]      r2_in;
   logic             busy, done, mem_rd_en;
   logic [IDX_W-1:0] mem_addr;
   logic [23:0]      mem_rdata;
   logic [7:0]       x1, y1, z1, x2, y2, z2;
   logic [15:0]      r2;
   logic             is_neighbor;
   logic             nb_valid;
   logic             nb_ready;
   logic [IDX_W-1:0] nb_idx;
   logic [IDX_W:0]   nb_count;

   logic [23:0] mem [NP];

   int n_cmp = 0;
   int n_bad = 0;

   neighbor_scan #(.IDX_W(IDX_W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .query_idx(query_idx),
      .n_points(n_points), .r2_in(r2_in), .busy(busy), .done(done),
      .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
      .x1(x1), .y1(y1), .z1(z1), .x2(x2), .y2(y2), .z2(z2), .r2(r2),
      .is_neighbor(is_neighbor), .nb_valid(nb_valid), .nb_ready(nb_ready),
      .nb_idx(nb_idx), .nb_count(nb_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr];

   function automatic int dist2(input logic [23:0] a, input logic [23:0] b);
      int dx, dy, dz;
      dx = int'(a[23:16]) - int'(b[23:16]);
      dy = int'(a[15:8])  - int'(b[15:8]);
      dz = int'(a[7:0])   - int'(b[7:0]);
      return dx*dx + dy*dy + dz*dz;
   endfunction

   assign is_neighbor = (dist2({x1, y1, z1}, {x2, y2, z2}) < int'(r2));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // mode 0: ready always high, 1: five stall cycles on first emit, 2: random ready
   task automatic run_scan(input int q, input int n, input int r2v, input int mode,
                           input bit busy_start, output int done_cyc);
      int exp_q[$];
      int got[$];
      int stalls, stall_left, held_idx;
      bit was_stall, rd_seen, rdy;
      for (int j = 0; j < n; j++)
         if (j != q && dist2(mem[q], mem[j]) < r2v) exp_q.push_back(j);
      stalls = 0; stall_left = 5; held_idx = 0; was_stall = 0; rd_seen = 0;
      done_cyc = -1;
      @(negedge clk);
      query_idx = q[IDX_W-1:0];
      n_points  = n[IDX_W:0];
      r2_in     = r2v[15:0];
      start     = 1'b1;
      nb_ready  = 1'b1;
      @(posedge clk);
      for (int cyc = 1; cyc < 400; cyc++) begin
         @(negedge clk);
         if (busy_start && cyc == 3) begin
            start     = 1'b1;
            query_idx = ~q[IDX_W-1:0];
            n_points  = 5'd3;
            r2_in     = 16'hFFFF;
         end else begin
            start = 1'b0;
         end
         if (mem_rd_en) rd_seen = 1'b1;
         if (was_stall) begin
            check("hold_valid", nb_valid, 1);
            check("hold_idx", nb_idx, held_idx);
         end
         if (done) begin
            done_cyc = cyc;
            break;
         end
         if (nb_valid) begin
            if (mode == 0) rdy = 1'b1;
            else if (mode == 1) begin
               rdy = (stall_left == 0);
               if (stall_left > 0) stall_left--;
            end else rdy = $urandom_range(0, 1) == 1;
            nb_ready = rdy;
            if (rdy) got.push_back(int'(nb_idx));
            else stalls++;
            was_stall = !rdy;
            held_idx  = int'(nb_idx);
         end else begin
            was_stall = 1'b0;
            nb_ready  = (mode == 2) ? ($urandom_range(0, 1) == 1) : 1'b1;
         end
      end
      start = 1'b0;
      if (done_cyc < 0) begin
         check("done_timeout", 0, 1);
      end else begin
         check("done_cycle", done_cyc, (n == 0) ? 1 : 3 + 3*n + exp_q.size() + stalls);
         check("nb_count", nb_count, exp_q.size());
         check("emit_count", got.size(), exp_q.size());
         for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            check("emit_idx", got[i], exp_q[i]);
         if (n == 0) check("no_rd_en", rd_seen, 0);
         else begin
            check("query_xyz", {x1, y1, z1}, mem[q]);
            check("r2_out", r2, r2v);
         end
         @(negedge clk);
         check("busy_after_done", busy, 0);
         check("nb_count_stable", nb_count, exp_q.size());
      end
   endtask

   int dc;

   initial begin
      rst_n = 1'b0; start = 1'b0; query_idx = '0; n_points = '0;
      r2_in = '0; nb_ready = 1'b0;
      for (int i = 0; i < NP; i++) mem[i] = 24'hC8C8C8;
      mem[0] = {8'd10, 8'd10, 8'd10};
      mem[1] = {8'd12, 8'd11, 8'd10};
      mem[2] = {8'd50, 8'd50, 8'd50};
      mem[3] = {8'd10, 8'd10, 8'd13};
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_valid", nb_valid, 0);
      check("rst_rd_en", mem_rd_en, 0);
      check("rst_count", nb_count, 0);
      check("rst_r2", r2, 0);
      rst_n = 1'b1;

      run_scan(0, 4, 10, 0, 1'b0, dc); check("basic_done17", dc, 17);
      run_scan(0, 4, 10, 1, 1'b0, dc); check("bp_done22", dc, 22);
      run_scan(0, 4, 9, 0, 1'b0, dc);  check("r2_9_done", dc, 16);
      run_scan(0, 4, 0, 0, 1'b0, dc);  check("r2_0_done", dc, 15);
      run_scan(0, 0, 10, 0, 1'b0, dc); check("n0_done1", dc, 1);
      run_scan(0, 4, 10, 0, 1'b1, dc); check("busy_start_done", dc, 17);

      for (int i = 0; i < NP; i++) mem[i] = {8'd7, 8'd7, 8'd7};
      run_scan(15, 16, 1, 0, 1'b0, dc); check("full_done", dc, 66);

      mem[0] = {8'd10, 8'd10, 8'd10};
      mem[1] = {8'd12, 8'd11, 8'd10};
      mem[2] = {8'd50, 8'd50, 8'd50};
      mem[3] = {8'd10, 8'd10, 8'd13};
      @(negedge clk);
      query_idx = '0; n_points = 5'd4; r2_in = 16'd10; start = 1'b1; nb_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 200 && !(nb_valid && nb_count == 5'd1); i++) @(negedge clk);
      check("reach_emit", nb_valid, 1);
      rst_n = 1'b0; nb_ready = 1'b0;
      @(negedge clk);
      check("mid_rst_valid", nb_valid, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_done", done, 0);
      check("mid_rst_count", nb_count, 0);
      rst_n = 1'b1;
      run_scan(0, 4, 10, 0, 1'b0, dc); check("restart_done17", dc, 17);

      for (int t = 0; t < 10; t++) begin
         for (int i = 0; i < NP; i++)
            mem[i] = {8'($urandom_range(0, 12)), 8'($urandom_range(0, 12)), 8'($urandom_range(0, 12))};
         run_scan(int'($urandom_range(0, 15)), int'($urandom_range(0, 16)),
                  int'($urandom_range(0, 120)), 2, ($urandom_range(0, 1) == 1), dc);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
